// File: rtl/pmp_scan_pkg.sv
// Shared types for the PMP NAPOT region scanner: address modes, FSM states,
// decoded region record and the NAPOT mask helper.
package pmp_scan_pkg;

    localparam int PMP_ADDR_W = 32;

    typedef enum logic [1:0] {
        PMP_OFF   = 2'd0,
        PMP_TOR   = 2'd1,
        PMP_NA4   = 2'd2,
        PMP_NAPOT = 2'd3
    } pmp_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_WRITE = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic [PMP_ADDR_W-1:0] base;
        logic [PMP_ADDR_W-1:0] mask;
        logic                  valid;
    } region_t;

    // t trailing ones means a 2^(t+1)-unit region; 33-bit math lets t=31 wrap to mask 0.
    function automatic logic [PMP_ADDR_W-1:0] napot_mask(input logic [4:0] t,
                                                         input logic       all_ones);
        logic [PMP_ADDR_W:0] m;
        m = ~((33'd2 << t) - 33'd1);
        return all_ones ? '0 : m[PMP_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/lzc32.sv
// Leading/trailing zero counter; MODE=0 counts trailing zeros, MODE=1 leading.
// empty_o flags an all-zero input (cnt_o is then 0).
module lzc32 #(
    parameter int WIDTH = 32,
    parameter bit MODE  = 1'b0
) (
    input  logic [WIDTH-1:0]         in_i,
    output logic [$clog2(WIDTH)-1:0] cnt_o,
    output logic                     empty_o
);
    localparam int CNT_W = $clog2(WIDTH);

    always_comb begin
        cnt_o   = '0;
        empty_o = (in_i == '0);
        if (MODE == 1'b0) begin
            // scan downward so the lowest set bit wins
            for (int i = WIDTH - 1; i >= 0; i--)
                if (in_i[i]) cnt_o = CNT_W'(i);
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (in_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/pmp_napot_scan.sv
// Sequential PMP table decoder: two cycles per entry (COUNT, WRITE) turn pmpaddr/mode
// into registered base/mask/valid. Optional per-entry write lock via PMP_NAPOT_LOCK_EN.
module pmp_napot_scan
    import pmp_scan_pkg::*;
#(
    parameter int NR_ENTRIES = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 start_i,
    input  logic [NR_ENTRIES-1:0][ADDR_W-1:0]    pmpaddr_i,
    input  logic [NR_ENTRIES-1:0][1:0]           mode_i,
`ifdef PMP_NAPOT_LOCK_EN
    input  logic [NR_ENTRIES-1:0]                lock_i,
`endif
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [NR_ENTRIES-1:0][ADDR_W-1:0]    base_o,
    output logic [NR_ENTRIES-1:0][ADDR_W-1:0]    mask_o,
    output logic [NR_ENTRIES-1:0]                valid_o
);
    localparam int IDX_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pending_q, pending_d;
    logic             done_q, done_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             ones_q, ones_d;

    logic [4:0]        lzc_cnt;
    logic              lzc_empty;
    logic [ADDR_W-1:0] cur_addr;
    logic              last_entry;
    logic              wr_en;
    region_t           region_d;
    region_t           region_q [NR_ENTRIES];

    assign cur_addr   = pmpaddr_i[idx_q];
    assign last_entry = (idx_q == IDX_W'(NR_ENTRIES - 1));

    // trailing zeros of ~pmpaddr == trailing ones of pmpaddr
    lzc32 #(
        .WIDTH (32),
        .MODE  (1'b0)
    ) u_lzc (
        .in_i    (~cur_addr),
        .cnt_o   (lzc_cnt),
        .empty_o (lzc_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            ones_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            ones_q    <= ones_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        ones_d    = ones_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_COUNT;
                    idx_d   = '0;
                end
            end
            S_COUNT: begin
                cnt_d   = lzc_cnt;
                ones_d  = lzc_empty;
                state_d = S_WRITE;
                if (start_i) pending_d = 1'b1;
            end
            S_WRITE: begin
                if (start_i) pending_d = 1'b1;
                if (last_entry) begin
                    done_d = 1'b1;
                    // a start seen anywhere in the scan restarts without an idle gap
                    if (pending_q || start_i) begin
                        state_d   = S_COUNT;
                        idx_d     = '0;
                        pending_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_COUNT;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        region_d = '0;
        unique case (pmp_mode_e'(mode_i[idx_q]))
            PMP_NA4: begin
                region_d.base  = cur_addr;
                region_d.mask  = '1;
                region_d.valid = 1'b1;
            end
            PMP_NAPOT: begin
                region_d.mask  = napot_mask(cnt_q, ones_q);
                region_d.base  = cur_addr & region_d.mask;
                region_d.valid = 1'b1;
            end
            default: region_d = '0;
        endcase
    end

`ifdef PMP_NAPOT_LOCK_EN
    assign wr_en = (state_q == S_WRITE) && !lock_i[idx_q];
`else
    assign wr_en = (state_q == S_WRITE);
`endif

    for (genvar e = 0; e < NR_ENTRIES; e++) begin : g_entry
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)
                region_q[e] <= '0;
            else if (wr_en && idx_q == IDX_W'(e))
                region_q[e] <= region_d;
        end
        assign base_o[e]  = region_q[e].base;
        assign mask_o[e]  = region_q[e].mask;
        assign valid_o[e] = region_q[e].valid;
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;

endmodule

// File: doc/pmp_napot_scan.md
PMP_NAPOT_SCAN -- requirements
Module: pmp_napot_scan

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 8, number of PMP entries scanned (1..16).
REQ-002 SHALL have parameter ADDR_W, default 32, pmpaddr width; fixed at 32.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  request a full table rescan; one-cycle pulse or level.
REQ-006 SHALL have port pmpaddr_i  input  NR_ENTRIES x 32  current pmpaddr CSR values.
REQ-007 SHALL have port mode_i  input  NR_ENTRIES x 2  address-matching mode: OFF=0, TOR=1, NA4=2, NAPOT=3.
REQ-008 SHALL have port busy_o  output  1  high while a scan is in progress.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse when a scan completes.
REQ-010 SHALL have port base_o  output  NR_ENTRIES x 32  decoded region base, pmpaddr units.
REQ-011 SHALL have port mask_o  output  NR_ENTRIES x 32  decoded compare mask; 1 = bit compared.
REQ-012 SHALL have port valid_o  output  NR_ENTRIES  entry holds a decoded NA4/NAPOT region.

Function
REQ-013 SHALL implement FSM states IDLE, COUNT, WRITE, with an entry index idx of width clog2(NR_ENTRIES).
REQ-014 SHALL leave IDLE for COUNT when start_i=1, with idx=0 and busy_o=1 from the next cycle.
REQ-015 SHALL, in COUNT, feed ~pmpaddr_i[idx] to the trailing-zero counter (count t = trailing ones of pmpaddr) and register t (0..31) plus all_ones (counter empty flag).
REQ-016 SHALL, in WRITE, update entry idx: NAPOT -> mask = ~((2<<t)-1), computed in 33 bits and truncated; mask = 0 when all_ones.
REQ-017 SHALL, in WRITE, set NAPOT base = pmpaddr_i[idx] & mask; NA4 -> mask = 0xFFFF_FFFF, base = pmpaddr_i[idx]; NA4 and NAPOT set valid=1.
REQ-018 SHALL, in WRITE, handle OFF and TOR entries: valid=0, base=0, mask=0.
REQ-019 SHALL sample pmpaddr_i/mode_i live in COUNT and WRITE; a change between those two cycles is caught by the pending rule below.
REQ-020 SHALL move WRITE -> COUNT with idx+1 when idx < NR_ENTRIES-1; otherwise WRITE -> IDLE with done_o=1 for exactly one cycle and busy_o=0.
REQ-021 SHALL give a scan latency of exactly 2*NR_ENTRIES cycles from the start-accept edge to the done_o edge.
REQ-022 SHALL, when start_i=1 while busy_o=1, set a pending flag; at scan end done_o still pulses and the FSM goes directly to COUNT with idx=0, clearing pending (no IDLE cycle).
REQ-023 SHALL, when start_i=1 in the final WRITE cycle, also trigger the immediate rescan of REQ-022.
REQ-024 SHALL keep base_o/mask_o/valid_o stable except for the single entry written in WRITE.
REQ-025 SHALL drive base_o/mask_o/valid_o directly from registers (no combinational path from inputs).

Reset
REQ-026 SHALL, on rst_ni=0 at any time (including mid-scan), asynchronously set: state=IDLE, idx=0, pending=0, busy_o=0, done_o=0, all base_o/mask_o=0, all valid_o=0.
REQ-027 SHALL, after reset release, not scan until start_i is seen; no scan occurs automatically.

Configuration
REQ-028 SHALL support macro PMP_NAPOT_LOCK_EN: when defined, add input lock_i (NR_ENTRIES) and leave locked entries unwritten in WRITE (all three fields hold), while timing is unchanged.
REQ-029 SHALL, without PMP_NAPOT_LOCK_EN, have no lock_i port and write every entry.

Structure
REQ-030 SHALL place in shared package pmp_scan_pkg: the pmp_mode_e enum (OFF/TOR/NA4/NAPOT), the scan_state_e enum, and the region_t struct {base, mask, valid}.
REQ-031 SHALL instantiate exactly one sub-module: the team's 32-bit counter lzc32 with WIDTH=32, MODE=0 (trailing).

Verification
REQ-032 SHALL cover: NAPOT pmpaddr 0x0000_0FFF -> t=12, mask 0xFFFF_E000, base 0x0000_0000, valid=1.
REQ-033 SHALL cover: NAPOT pmpaddr 0xFFFF_FFFF -> mask 0x0000_0000, base 0, valid=1; NAPOT 0x7FFF_FFFF -> mask 0, base 0.
REQ-034 SHALL cover: NAPOT 0x1234_5670 -> mask 0xFFFF_FFFE, base 0x1234_5670; NA4 0x1234_5671 -> mask 0xFFFF_FFFF, base 0x1234_5671; TOR -> valid=0.
REQ-035 SHALL cover: start pulse with NR_ENTRIES=8 -> done_o exactly 16 cycles later; start_i again at cycle 5 -> second scan begins the cycle after done_o, total 32 cycles.
REQ-036 SHALL cover: rst_ni low during cycle 7 of a scan -> all outputs 0 immediately, IDLE, no done_o.
REQ-037 SHALL cover, with PMP_NAPOT_LOCK_EN: lock_i[2]=1 -> entry 2 keeps its prior value while others update.
